mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, memory address width.
REQ-002 SHALL have parameter DW, default 32, memory data width.
REQ-003 SHALL have parameter STARVE, default 3, consecutive lost IDLE cycles after which fetch overrides data priority (legal 1..7).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  instruction-fetch read request, held until granted.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DW  fetch read data.
- d_req  in  1  data load/store request, held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DW  load data.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_wren  out  1  memory write enable.
- mem_q  in  DW  memory read data, valid one cycle after address.

Function
REQ-006 SHALL implement FSM states IDLE and RDWAIT; only one read outstanding at a time.
REQ-007 In IDLE with any request, SHALL grant exactly one requester combinationally in the same cycle: gnt high, mem_addr/mem_wdata/mem_wren driven from the winner.
REQ-008 Arbitration SHALL be: data wins if d_req=1 and wait_ctr<STARVE; otherwise fetch wins if if_req=1.
REQ-009 wait_ctr (3 bits) SHALL increment, saturating at STARVE, in each IDLE cycle where if_req=1 and d_gnt=1; it SHALL clear when if_gnt=1 or if_req=0; it SHALL hold in RDWAIT.
REQ-010 Granted read (fetch, or data with d_we=0) SHALL move IDLE->RDWAIT; mem_wren=0.
REQ-011 Granted store SHALL assert mem_wren=1 for that single cycle, mem_wdata=d_wdata; FSM stays IDLE, and the next cycle may grant again.
REQ-012 In RDWAIT, SHALL assert exactly one of if_rvalid/d_rvalid, for the granted read's owner, with its rdata=mem_q; FSM returns to IDLE at cycle end.
REQ-013 In RDWAIT, SHALL assert no gnt and mem_wren=0, regardless of requests.
REQ-014 Read latency SHALL be exactly 1 cycle from gnt to rvalid; read throughput 1 per 2 cycles; store throughput 1 per cycle.
REQ-015 When no gnt, mem_addr and mem_wdata SHALL be 0 and mem_wren SHALL be 0.
REQ-016 if_rdata/d_rdata SHALL equal mem_q when their rvalid=1 and 0 otherwise.
REQ-017 Requester changing addr/data while req=1 and ungranted is legal; the value sampled at the gnt cycle is the one used.
REQ-018 With simultaneous if_req and d_req, fetch not starved, SHALL grant data and hold fetch pending.

Reset
REQ-019 While rst=1: FSM->IDLE, wait_ctr->0, owner->0; all gnt, rvalid and mem_wren SHALL be 0; mem_addr, mem_wdata and rdata SHALL be 0.
REQ-020 rst asserted during RDWAIT SHALL suppress that cycle's rvalid; the pending read is discarded.
REQ-021 First grant possible in the first cycle with rst=0.

Verification
REQ-022 Fetch only: if_req=1, if_addr=0x10, memory[0x10]=0xDEADBEEF -> if_gnt at cycle N, if_rvalid=1 with if_rdata=0xDEADBEEF at N+1, next gnt no earlier than N+2.
REQ-023 Simultaneous: if_req=d_req=1, d_we=0, d_addr=0x20 -> d_gnt at N, d_rvalid at N+1, if_gnt at N+2.
REQ-024 Starvation: d_req=1 continuously with stores, if_req=1 -> d_gnt on 3 consecutive cycles, then if_gnt on the 4th, wait_ctr cleared.
REQ-025 Store: d_req=1, d_we=1, d_addr=0x05, d_wdata=0x12345678 -> mem_wren=1, mem_addr=0x05, mem_wdata=0x12345678 for one cycle, no d_rvalid; a following load of 0x05 returns 0x12345678.
REQ-026 Reset mid-read: grant fetch at N, rst=1 at N+1 -> if_rvalid=0 at N+1, all outputs 0, first grant possible in the cycle rst falls.
REQ-027 Idle: no requests for 10 cycles -> all gnt, rvalid and mem_wren stay 0, mem_addr=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between instruction fetch and data load/store with starvation guard
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int STARVE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q
);
  typedef enum logic {IDLE, RDWAIT} state_t;
  state_t state, state_nxt;
  logic [2:0] wait_ctr, wait_nxt;
  logic owner, idle, rd, d_win, f_win;
  always_comb begin
    idle = !rst && state == IDLE;
    rd = !rst && state == RDWAIT;
    d_win = idle && d_req && wait_ctr < 3'(STARVE);
    f_win = idle && if_req && !d_win;
    state_nxt = (f_win || (d_win && !d_we)) ? RDWAIT : IDLE;
    wait_nxt = rd ? wait_ctr : (f_win || !if_req) ? 3'd0 : (wait_ctr < 3'(STARVE)) ? wait_ctr + 3'd1 : wait_ctr;
  end
  assign if_gnt = f_win;
  assign d_gnt = d_win;
  assign mem_addr = d_win ? d_addr : f_win ? if_addr : '0;
  assign mem_wdata = d_win ? d_wdata : '0;
  assign mem_wren = d_win && d_we;
  assign if_rvalid = rd && !owner;
  assign d_rvalid = rd && owner;
  assign if_rdata = if_rvalid ? mem_q : '0;
  assign d_rdata = d_rvalid ? mem_q : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wait_ctr <= '0;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      wait_ctr <= wait_nxt;
      if (idle && state_nxt == RDWAIT) owner <= d_win;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int ST = 3;
  logic clk = 1'b0;
  logic rst, if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, mem_wdata, mem_q, if_rdata, d_rdata;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wren;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  int n_chk = 0;
  int n_pass = 0;
  int pend = 0;
  int lost = 0;
  logic [DW-1:0] pend_data = '0;
  logic e_ig, e_dg, e_we, e_irv, e_drv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_ird, e_drd;
  mem_arbiter #(.AW(AW), .DW(DW), .STARVE(ST)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    mem_q <= mem[mem_addr];
  end
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic cyc();
    bit dwin, fwin, st;
    int npend, nlost;
    logic [DW-1:0] npd;
    #1;
    {e_ig, e_dg, e_we, e_irv, e_drv} = '0;
    e_addr = '0; e_wd = '0; e_ird = '0; e_drd = '0;
    npend = 0; nlost = 0; npd = '0; st = 0;
    if (!rst) begin
      if (pend != 0) begin
        e_irv = pend == 1;
        e_drv = pend == 2;
        e_ird = pend == 1 ? pend_data : '0;
        e_drd = pend == 2 ? pend_data : '0;
        nlost = lost;
      end else begin
        dwin = d_req && lost < ST;
        fwin = !dwin && if_req;
        e_dg = dwin;
        e_ig = fwin;
        e_addr = dwin ? d_addr : fwin ? if_addr : '0;
        e_wd = dwin ? d_wdata : '0;
        e_we = dwin && d_we;
        if (dwin && !d_we) begin npend = 2; npd = ref_mem[d_addr]; end
        if (fwin) begin npend = 1; npd = ref_mem[if_addr]; end
        st = dwin && d_we;
        nlost = (!if_req || fwin) ? 0 : (lost + 1 > ST ? ST : lost + 1);
      end
    end
    chk("if_gnt", 32'(if_gnt), 32'(e_ig));
    chk("d_gnt", 32'(d_gnt), 32'(e_dg));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", mem_wdata, e_wd);
    chk("mem_wren", 32'(mem_wren), 32'(e_we));
    chk("if_rvalid", 32'(if_rvalid), 32'(e_irv));
    chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
    chk("if_rdata", if_rdata, e_ird);
    chk("d_rdata", d_rdata, e_drd);
    @(posedge clk);
    if (st) ref_mem[d_addr] = d_wdata;
    pend = npend;
    pend_data = npd;
    lost = nlost;
    @(negedge clk);
  endtask
  initial begin
    rst = 1; if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    @(negedge clk);
    if_req = 1; d_req = 1; d_addr = 8'h33; d_wdata = 32'h55;
    cyc(); cyc();
    rst = 0; if_req = 0; d_req = 0;
    for (int i = 0; i < 10; i++) cyc();
    if_req = 1; if_addr = 8'h10;
    #1 chk("fetch_gnt", 32'(if_gnt), 32'd1);
    cyc();
    if_req = 0;
    #1 chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
    cyc();
    if_req = 1; d_req = 1; d_we = 0; d_addr = 8'h20;
    #1 chk("sim_d_gnt", 32'(d_gnt), 32'd1);
    cyc();
    d_req = 0;
    #1 chk("sim_d_rvalid", 32'(d_rvalid), 32'd1);
    cyc();
    #1 chk("sim_if_gnt", 32'(if_gnt), 32'd1);
    cyc();
    if_req = 0;
    cyc();
    if_req = 1; d_req = 1; d_we = 1;
    for (int i = 0; i < 3; i++) begin
      d_addr = 8'(i + 64); d_wdata = $urandom;
      #1 chk("starve_d_gnt", 32'(d_gnt), 32'd1);
      cyc();
    end
    #1 chk("starve_if_gnt", 32'(if_gnt), 32'd1);
    cyc();
    if_req = 0; d_req = 0;
    cyc();
    d_req = 1; d_we = 1; d_addr = 8'h05; d_wdata = 32'h12345678;
    #1 chk("store_wren", 32'(mem_wren), 32'd1);
    cyc();
    d_we = 0; d_wdata = '0;
    cyc();
    d_req = 0;
    #1 chk("load_back", d_rdata, 32'h12345678);
    cyc();
    if_req = 1; if_addr = 8'h77;
    cyc();
    if_req = 0; rst = 1;
    #1 chk("rst_rvalid", 32'(if_rvalid), 32'd0);
    cyc();
    rst = 0; if_req = 1;
    #1 chk("rst_regrant", 32'(if_gnt), 32'd1);
    cyc();
    if_req = 0;
    cyc();
    for (int i = 0; i < 600; i++) begin
      if (!if_req || e_ig) if_req = $urandom_range(0, 2) != 0;
      if (!d_req || e_dg) begin
        d_req = $urandom_range(0, 2) != 0;
        d_we = $urandom_range(0, 1) != 0;
      end
      if_addr = 8'($urandom);
      d_addr = 8'($urandom_range(0, 15));
      d_wdata = $urandom;
      rst = $urandom_range(0, 49) == 0;
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
